// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE/MEM bundle for the execute stage. The o_ovf member exists only
// when EXE_OVERFLOW_TRAP_EN is defined.
interface exe_stage_if;
   logic        i_stall_exe;
   logic        i_write_mem;
   logic        i_write_regfile;
   logic        i_mem_to_regfile;
   logic        i_jal;
   logic        i_aluimm;
   logic        i_shift;
   logic [31:0] i_pc;
   logic [31:0] i_da;
   logic [31:0] i_db;
   logic [31:0] i_imm;
   logic [4:0]  i_rn;
   logic [14:0] i_ALUControl;
   logic [7:0]  i_mem_control;

   logic        o_write_mem;
   logic        o_write_regfile;
   logic        o_mem_to_regfile;
   logic [4:0]  o_rn;
   logic [7:0]  o_mem_control;
   logic [31:0] o_result;
   logic [31:0] o_store_data;
   logic        o_stallreq;
`ifdef EXE_OVERFLOW_TRAP_EN
   logic        o_ovf;
`endif

   modport master (
`ifdef EXE_OVERFLOW_TRAP_EN
      input  o_ovf,
`endif
      output i_stall_exe, i_write_mem, i_write_regfile, i_mem_to_regfile,
             i_jal, i_aluimm, i_shift, i_pc, i_da, i_db, i_imm, i_rn,
             i_ALUControl, i_mem_control,
      input  o_write_mem, o_write_regfile, o_mem_to_regfile, o_rn,
             o_mem_control, o_result, o_store_data, o_stallreq
   );

   modport slave (
`ifdef EXE_OVERFLOW_TRAP_EN
      output o_ovf,
`endif
      input  i_stall_exe, i_write_mem, i_write_regfile, i_mem_to_regfile,
             i_jal, i_aluimm, i_shift, i_pc, i_da, i_db, i_imm, i_rn,
             i_ALUControl, i_mem_control,
      output o_write_mem, o_write_regfile, o_mem_to_regfile, o_rn,
             o_mem_control, o_result, o_store_data, o_stallreq
   );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU/shift/link datapath, HI/LO registers and a
// 32-step restoring divider. Optional EXE_OVERFLOW_TRAP_EN adds o_ovf.
module exe_stage #(
   parameter logic [31:0] JAL_OFFSET = 32'd8,
   parameter logic [31:0] HILO_RST   = 32'h0
) (
   input logic       clk,
   input logic       reset,
   exe_stage_if.slave bus
);
   localparam int OP_ADD = 0,  OP_SUB = 1,  OP_AND = 2,  OP_OR  = 3,  OP_XOR = 4;
   localparam int OP_NOR = 5,  OP_SLT = 6,  OP_SLTU = 7, OP_SLL = 8,  OP_SRL = 9;
   localparam int OP_SRA = 10, OP_LUI = 11, OP_DIV = 12, OP_DIVU = 13, OP_MFHILO = 14;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] hi, lo;
   logic [31:0] rem_r, quot_r, divisor_r;
   logic [4:0]  count;
   logic        neg_q, neg_r;

   logic [31:0] op_a, op_b, alu_res;
   logic [4:0]  shamt;
   logic [31:0] sum, diff;
   logic        add_ovf, sub_ovf;

   assign op_a  = bus.i_da;
   assign op_b  = bus.i_aluimm ? bus.i_imm : bus.i_db;
   assign shamt = bus.i_shift ? bus.i_imm[10:6] : bus.i_da[4:0];
   assign sum   = op_a + op_b;
   assign diff  = op_a - op_b;
   assign add_ovf = (op_a[31] == op_b[31]) && (sum[31]  != op_a[31]);
   assign sub_ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      alu_res = '0;
      case (1'b1)
         bus.i_ALUControl[OP_ADD]:  alu_res = sum;
         bus.i_ALUControl[OP_SUB]:  alu_res = diff;
         bus.i_ALUControl[OP_AND]:  alu_res = op_a & op_b;
         bus.i_ALUControl[OP_OR]:   alu_res = op_a | op_b;
         bus.i_ALUControl[OP_XOR]:  alu_res = op_a ^ op_b;
         bus.i_ALUControl[OP_NOR]:  alu_res = ~(op_a | op_b);
         bus.i_ALUControl[OP_SLT]:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         bus.i_ALUControl[OP_SLTU]: alu_res = {31'b0, op_a < op_b};
         bus.i_ALUControl[OP_SLL]:  alu_res = op_b << shamt;
         bus.i_ALUControl[OP_SRL]:  alu_res = op_b >> shamt;
         bus.i_ALUControl[OP_SRA]:  alu_res = $signed(op_b) >>> shamt;
         bus.i_ALUControl[OP_LUI]:  alu_res = {op_b[15:0], 16'h0};
         default:                   alu_res = '0;
      endcase
   end

   always_comb begin
      if (bus.i_jal)                          bus.o_result = bus.i_pc + JAL_OFFSET;
      else if (bus.i_ALUControl[OP_MFHILO])   bus.o_result = bus.i_imm[0] ? hi : lo;
      else                                    bus.o_result = alu_res;
   end

   // Divider: operands are converted to magnitudes at launch, signs fixed on write-back.
   logic        div_req, div_signed, div_zero;
   logic [31:0] abs_a, abs_b;
   logic [32:0] trial, trial_sub;
   logic        trial_ge;

   assign div_req    = bus.i_ALUControl[OP_DIV] | bus.i_ALUControl[OP_DIVU];
   assign div_signed = bus.i_ALUControl[OP_DIV];
   assign div_zero   = (bus.i_db == 32'h0);
   assign abs_a      = (div_signed && bus.i_da[31]) ? -bus.i_da : bus.i_da;
   assign abs_b      = (div_signed && bus.i_db[31]) ? -bus.i_db : bus.i_db;
   assign trial      = {rem_r, quot_r[31]};
   assign trial_sub  = trial - {1'b0, divisor_r};
   assign trial_ge   = trial >= {1'b0, divisor_r};

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (div_req) state_nxt = div_zero ? DONE : BUSY;
         BUSY:    if (count == 5'd31) state_nxt = DONE;
         DONE:    if (!bus.i_stall_exe) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Reset also masks the request combinationally so an aborted divide releases the pipe at once.
   always_comb begin
      bus.o_stallreq = !reset && ((state == IDLE && div_req) || state == BUSY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi        <= HILO_RST;
         lo        <= HILO_RST;
         rem_r     <= '0;
         quot_r    <= '0;
         divisor_r <= '0;
         count     <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (div_req) begin
               count <= '0;
               if (div_zero) begin
                  rem_r  <= bus.i_da;
                  quot_r <= 32'hFFFF_FFFF;
                  neg_q  <= 1'b0;
                  neg_r  <= 1'b0;
               end else begin
                  rem_r     <= '0;
                  quot_r    <= abs_a;
                  divisor_r <= abs_b;
                  neg_q     <= div_signed & (bus.i_da[31] ^ bus.i_db[31]);
                  neg_r     <= div_signed & bus.i_da[31];
               end
            end
            BUSY: begin
               rem_r  <= trial_ge ? trial_sub[31:0] : trial[31:0];
               quot_r <= {quot_r[30:0], trial_ge};
               count  <= count + 5'd1;
            end
            DONE: if (!bus.i_stall_exe) begin
               hi <= neg_r ? -rem_r  : rem_r;
               lo <= neg_q ? -quot_r : quot_r;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_write_mem      = bus.i_write_mem;
   assign bus.o_mem_to_regfile = bus.i_mem_to_regfile;
   assign bus.o_rn             = bus.i_rn;
   assign bus.o_mem_control    = bus.i_mem_control;
   assign bus.o_store_data     = bus.i_db;

`ifdef EXE_OVERFLOW_TRAP_EN
   assign bus.o_ovf           = (bus.i_ALUControl[OP_ADD] & add_ovf) |
                                (bus.i_ALUControl[OP_SUB] & sub_ovf);
   assign bus.o_write_regfile = bus.i_write_regfile & ~bus.o_ovf;
`else
   assign bus.o_write_regfile = bus.i_write_regfile;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expected responses, a negedge
// monitor pops and compares. Covers EXE_OVERFLOW_TRAP_EN when defined.
module tb_exe_stage;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   exe_stage_if bus ();
   exe_stage dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      string       tag;
      logic [31:0] result;
      logic        chk_result;
      logic        stallreq;
      logic [31:0] store_data;
      logic [4:0]  rn;
      logic [7:0]  mem_control;
      logic        wmem, wreg, m2r, ovf;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference ALU from the instruction semantics.
   function automatic logic [31:0] model_result(input int op, input logic [31:0] a, b, imm, pc,
                                                input logic jal, aluimm, shft);
      logic [31:0] bb;
      int unsigned sh;
      bb = aluimm ? imm : b;
      sh = shft ? int'(imm[10:6]) : int'(a[4:0]);
      if (jal)      return pc + 32'd8;
      if (op == 14) return imm[0] ? m_hi : m_lo;
      case (op)
         0:  return a + bb;
         1:  return a - bb;
         2:  return a & bb;
         3:  return a | bb;
         4:  return a ^ bb;
         5:  return ~(a | bb);
         6:  return (int'(a) < int'(bb)) ? 32'd1 : 32'd0;
         7:  return (a < bb) ? 32'd1 : 32'd0;
         8:  return bb << sh;
         9:  return bb >> sh;
         10: return $signed(bb) >>> sh;
         11: return {bb[15:0], 16'h0};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_ovf(input int op, input logic [31:0] a, b, imm, input logic aluimm);
      longint sa, sbv, s;
      sa  = longint'(int'(a));
      sbv = longint'(int'(aluimm ? imm : b));
      if (op == 0)      s = sa + sbv;
      else if (op == 1) s = sa - sbv;
      else              return 1'b0;
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic void div_model(input logic sgn, input logic [31:0] a, b,
                                     output logic [31:0] q, output logic [31:0] r);
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'h0;
      end else if (sgn) begin
         q = 32'(int'(a) / int'(b)); r = 32'(int'(a) % int'(b));
      end else begin
         q = a / b; r = a % b;
      end
   endfunction

   // One pipeline cycle: drive inputs just after the edge and queue the expected response.
   task automatic cycle(input int op, input logic [31:0] a, b, imm,
                        input logic jal, aluimm, shft, stall_exe, rst_val, exp_stall, chk_res,
                        input string tag);
      exp_t e;
      logic ovf;
      @(posedge clk); #1;
      reset = rst_val;
      if (rst_val) begin m_hi = 32'h0; m_lo = 32'h0; end
      bus.i_ALUControl     = (op < 0) ? 15'd0 : (15'd1 << op);
      bus.i_da             = a;
      bus.i_db             = b;
      bus.i_imm            = imm;
      bus.i_jal            = jal;
      bus.i_aluimm         = aluimm;
      bus.i_shift          = shft;
      bus.i_stall_exe      = stall_exe;
      bus.i_pc             = $urandom & 32'hFFFF_FFFC;
      bus.i_rn             = 5'($urandom);
      bus.i_mem_control    = 8'($urandom);
      bus.i_write_mem      = 1'($urandom);
      bus.i_write_regfile  = 1'($urandom);
      bus.i_mem_to_regfile = 1'($urandom);
`ifdef EXE_OVERFLOW_TRAP_EN
      ovf = model_ovf(op, a, b, imm, aluimm);
`else
      ovf = 1'b0;
`endif
      e.tag         = tag;
      e.result      = model_result(op, a, b, imm, bus.i_pc, jal, aluimm, shft);
      e.chk_result  = chk_res;
      e.stallreq    = exp_stall;
      e.store_data  = b;
      e.rn          = bus.i_rn;
      e.mem_control = bus.i_mem_control;
      e.wmem        = bus.i_write_mem;
      e.wreg        = bus.i_write_regfile & ~ovf;
      e.m2r         = bus.i_mem_to_regfile;
      e.ovf         = ovf;
      sb.push_back(e);
   endtask

   task automatic alu_op(input int op, input logic [31:0] a, b, imm,
                         input logic jal, aluimm, shft, input string tag);
      cycle(op, a, b, imm, jal, aluimm, shft, 1'b0, 1'b0, 1'b0, 1'b1, tag);
   endtask

   task automatic run_div(input logic sgn, input logic [31:0] a, b, input int hold, input string tag);
      logic [31:0] q, r;
      int          n;
      int          op;
      op = sgn ? 12 : 13;
      div_model(sgn, a, b, q, r);
      n = (b == 32'h0) ? 1 : 33;
      for (int i = 0; i < n; i++)
         cycle(op, a, b, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {tag, "_stall"});
      for (int i = 0; i < hold; i++)
         cycle(14, a, b, 32'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {tag, "_hold"});
      cycle(14, a, b, 32'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_done"});
      m_hi = r;
      m_lo = q;
      alu_op(14, $urandom, $urandom, 32'h0, 1'b0, 1'b0, 1'b0, {tag, "_lo"});
      alu_op(14, $urandom, $urandom, 32'h1, 1'b0, 1'b0, 1'b0, {tag, "_hi"});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.chk_result) check({e.tag, " result"}, bus.o_result, e.result);
         check({e.tag, " stallreq"},   32'(bus.o_stallreq),       32'(e.stallreq));
         check({e.tag, " store_data"}, bus.o_store_data,          e.store_data);
         check({e.tag, " rn"},         32'(bus.o_rn),             32'(e.rn));
         check({e.tag, " mem_ctl"},    32'(bus.o_mem_control),    32'(e.mem_control));
         check({e.tag, " wmem"},       32'(bus.o_write_mem),      32'(e.wmem));
         check({e.tag, " wreg"},       32'(bus.o_write_regfile),  32'(e.wreg));
         check({e.tag, " m2r"},        32'(bus.o_mem_to_regfile), 32'(e.m2r));
`ifdef EXE_OVERFLOW_TRAP_EN
         check({e.tag, " ovf"},        32'(bus.o_ovf),            32'(e.ovf));
`endif
      end
   end

   initial begin
      int          r, op;
      logic        jal;
      logic [31:0] a, b;
      reset = 1'b1;
      bus.i_ALUControl = '0;  bus.i_da = '0;  bus.i_db = '0;  bus.i_imm = '0;
      bus.i_jal = 1'b0;  bus.i_aluimm = 1'b0;  bus.i_shift = 1'b0;  bus.i_stall_exe = 1'b0;
      bus.i_pc = '0;  bus.i_rn = '0;  bus.i_mem_control = '0;
      bus.i_write_mem = 1'b0;  bus.i_write_regfile = 1'b0;  bus.i_mem_to_regfile = 1'b0;

      // Reset state: HI/LO at reset value, no stall request.
      cycle(14, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "reset_lo");
      cycle(14, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_hi");

      // Directed datapath cases.
      alu_op(0,  32'd7,        32'h0,        32'd5,        1'b0, 1'b1, 1'b0, "add_imm");
      alu_op(10, 32'h0,        32'hF000_0000, 32'h0000_0100, 1'b0, 1'b0, 1'b1, "sra");
      alu_op(6,  32'hFFFF_FFFF, 32'd1,       32'h0,        1'b0, 1'b0, 1'b0, "slt");
      alu_op(7,  32'hFFFF_FFFF, 32'd1,       32'h0,        1'b0, 1'b0, 1'b0, "sltu");
      alu_op(-1, 32'h1234_5678, 32'h9,       32'h5,        1'b0, 1'b0, 1'b0, "bubble");
      alu_op(14, 32'h1,        32'h2,        32'h1,        1'b1, 1'b0, 1'b0, "jal_over_mf");
      alu_op(11, 32'h0,        32'h0,        32'h0000_ABCD, 1'b0, 1'b1, 1'b0, "lui");
      alu_op(0,  32'h7FFF_FFFF, 32'h1,       32'h0,        1'b0, 1'b0, 1'b0, "add_ovf");
      alu_op(1,  32'h0,        32'h1,        32'h0,        1'b0, 1'b0, 1'b0, "sub_wrap");
      alu_op(1,  32'h8000_0000, 32'h1,       32'h0,        1'b0, 1'b0, 1'b0, "sub_ovf");

      // Divider corner cases.
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      run_div(1'b0, 32'd100, 32'd0, 3, "divu_by0");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min");
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1, "div_7_m2");

      // Reset while BUSY at count 10 aborts the divide.
      for (int i = 0; i < 11; i++)
         cycle(12, 32'd1000, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "abort_busy");
      cycle(12, 32'd1000, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "abort_rst");
      cycle(14, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "abort_lo");
      cycle(14, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "abort_hi");
      run_div(1'b0, 32'd1000, 32'd3, 0, "div_after_rst");

      // Randomized ALU traffic.
      for (int i = 0; i < 120; i++) begin
         r   = int'($urandom_range(0, 13));
         op  = (r < 12) ? r : ((r == 12) ? 14 : -1);
         jal = ($urandom_range(0, 7) == 0);
         if (jal && (op == 0 || op == 1)) op = 14;
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
         alu_op(op, a, b, $urandom, jal, 1'($urandom), 1'($urandom), "rand_alu");
      end

      // Randomized divides, mixing small divisors and zero.
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = (i == 3) ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
         run_div(1'($urandom), a, b, int'($urandom_range(0, 2)), "rand_div");
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
